// File: rtl/avalon_wait_slave.sv
// avalon_wait_slave: Avalon-MM slave target with a per-transfer programmable
// wait-request latency, byte-enabled register memory and master-violation flag.
module avalon_wait_slave #(
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8,
    parameter int MAXWAIT     = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NBADDRBITS-1:0]     address,
    input  logic [NBDATABYTES-1:0]    byteenable,
    input  logic [8*NBDATABYTES-1:0]  writedata,
    input  logic                      read,
    input  logic                      write,
    input  logic [3:0]                wait_cycles,
    output logic [8*NBDATABYTES-1:0]  readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      protocol_error,
    output logic [15:0]               rd_count,
    output logic [15:0]               wr_count
);

    localparam int DW    = 8 * NBDATABYTES;
    localparam int DEPTH = 1 << NBADDRBITS;
    localparam logic [3:0] MAXW = 4'((MAXWAIT > 15) ? 15 : MAXWAIT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [NBADDRBITS-1:0]   lat_addr;
    logic [NBDATABYTES-1:0]  lat_be;
    logic [DW-1:0]           lat_wd;
    logic                    lat_rd;
    logic                    lat_wr;
    logic [DW-1:0]           mem [DEPTH];

    logic                    req_one;
    logic                    req_both;
    logic [3:0]              lim;
    logic                    violation;
    logic                    start;

    logic                    do_rd;
    logic                    do_wr;
    logic                    set_err;
    logic [NBADDRBITS-1:0]   x_addr;
    logic [NBDATABYTES-1:0]  x_be;
    logic [DW-1:0]           x_wd;

    // Request decode, latency clamp and hold-check against the latched request
    always_comb begin
        req_one   = read ^ write;
        req_both  = read & write;
        lim       = (wait_cycles > MAXW) ? MAXW : wait_cycles;
        violation = (read != lat_rd) || (write != lat_wr) ||
                    (address != lat_addr) || (byteenable != lat_be) ||
                    (writedata != lat_wd);
        start     = (state == S_IDLE) && req_one && (lim != 4'd0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (req_one && lim != 4'd0) state_nxt = S_WAIT;
            S_WAIT: if (violation || cnt == 4'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and completion decode; everything quiet while reset is held
    always_comb begin
        waitrequest   = 1'b0;
        do_rd         = 1'b0;
        do_wr         = 1'b0;
        set_err       = 1'b0;
        x_addr        = address;
        x_be          = byteenable;
        x_wd          = writedata;
        if (rst) begin
            unique case (state)
                S_IDLE: begin
                    if (req_both) begin
                        set_err = 1'b1;
                    end else if (req_one) begin
                        if (lim == 4'd0) begin
                            do_rd = read;
                            do_wr = write;
                        end else begin
                            waitrequest = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    x_addr = lat_addr;
                    x_be   = lat_be;
                    x_wd   = lat_wd;
                    if (violation) begin
                        set_err = 1'b1;
                    end else if (cnt != 4'd0) begin
                        waitrequest = 1'b1;
                    end else begin
                        do_rd = lat_rd;
                        do_wr = lat_wr;
                    end
                end
                default: ;
            endcase
        end
        readdatavalid = do_rd;
        readdata      = do_rd ? mem[x_addr] : '0;
    end

    // Latch the request and run the wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_be   <= '0;
            lat_wd   <= '0;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
        end else if (start) begin
            cnt      <= lim - 4'd1;
            lat_addr <= address;
            lat_be   <= byteenable;
            lat_wd   <= writedata;
            lat_rd   <= read;
            lat_wr   <= write;
        end else if (state == S_WAIT) begin
            if (violation || cnt == 4'd0) cnt <= 4'd0;
            else                          cnt <= cnt - 4'd1;
        end
    end

    // Memory: cleared on reset, byte-lane merge at the write completion edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            for (int b = 0; b < NBDATABYTES; b++) begin
                if (x_be[b]) mem[x_addr][8*b +: 8] <= x_wd[8*b +: 8];
            end
        end
    end

    // Saturating transfer counters and sticky violation flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count       <= 16'd0;
            wr_count       <= 16'd0;
            protocol_error <= 1'b0;
        end else begin
            if (do_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (do_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (set_err) protocol_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_wait_slave.sv
// tb_avalon_wait_slave: directed and randomized transfers against a
// transaction-level model of the wait-request slave.
module tb_avalon_wait_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  address;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        read;
    logic        write;
    logic [3:0]  wait_cycles;
    logic [15:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        protocol_error;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    avalon_wait_slave #(
        .NBDATABYTES(2),
        .NBADDRBITS (8),
        .MAXWAIT    (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .read          (read),
        .write         (write),
        .wait_cycles   (wait_cycles),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .protocol_error(protocol_error),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    logic [15:0] mmem [256];
    int          mrd;
    int          mwr;
    bit          mperr;
    int          total = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mmem[i] = 16'h0;
        mrd   = 0;
        mwr   = 0;
        mperr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        @(negedge clk);
        chk({tag, "_rdcnt"}, rd_count, mrd);
        chk({tag, "_wrcnt"}, wr_count, mwr);
        chk({tag, "_perr"}, protocol_error, mperr);
    endtask

    // One legal transfer: waitrequest high for L cycles, completion in cycle L
    task automatic xfer(input bit is_rd, input logic [7:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        input logic [3:0] wc);
        int l;
        l = (int'(wc) > 15) ? 15 : int'(wc);
        read        = is_rd;
        write       = !is_rd;
        address     = a;
        byteenable  = be;
        writedata   = wd;
        wait_cycles = wc;
        for (int i = 0; i <= l; i++) begin
            @(negedge clk);
            chk("waitreq", waitrequest, (i < l));
            chk("rdvalid", readdatavalid, (is_rd && i == l));
            chk("rddata", readdata, (is_rd && i == l) ? mmem[a] : 16'h0);
            step();
            wait_cycles = 4'($urandom);
        end
        if (is_rd) begin
            if (mrd < 65535) mrd++;
        end else begin
            for (int b = 0; b < 2; b++)
                if (be[b]) mmem[a][8*b +: 8] = wd[8*b +: 8];
            if (mwr < 65535) mwr++;
        end
        read  = 1'b0;
        write = 1'b0;
        chk_regs("post");
        step();
    endtask

    initial begin
        rst         = 1'b0;
        address     = '0;
        byteenable  = '0;
        writedata   = '0;
        read        = 1'b0;
        write       = 1'b0;
        wait_cycles = '0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_waitreq", waitrequest, 0);
        chk("rst_rdvalid", readdatavalid, 0);
        chk("rst_rddata", readdata, 0);
        step();
        rst = 1'b1;
        chk_regs("rst");
        step();
        xfer(1, 8'h00, 2'b00, 16'h0, 4'd0);
        xfer(1, 8'hFF, 2'b00, 16'h0, 4'd0);

        xfer(0, 8'h10, 2'b11, 16'hBEEF, 4'd0);
        xfer(1, 8'h10, 2'b11, 16'h0, 4'd0);

        xfer(0, 8'h10, 2'b01, 16'h1234, 4'd3);
        xfer(1, 8'h10, 2'b00, 16'h0, 4'd2);

        read        = 1'b1;
        write       = 1'b1;
        address     = 8'h10;
        writedata   = 16'h7777;
        byteenable  = 2'b11;
        wait_cycles = 4'd3;
        @(negedge clk);
        chk("both_waitreq", waitrequest, 0);
        chk("both_rdvalid", readdatavalid, 0);
        step();
        read  = 1'b0;
        write = 1'b0;
        mperr = 1'b1;
        chk_regs("both");
        step();

        read        = 1'b1;
        address     = 8'h10;
        byteenable  = 2'b00;
        wait_cycles = 4'd4;
        @(negedge clk);
        chk("addrviol_wait", waitrequest, 1);
        step();
        address = 8'h11;
        @(negedge clk);
        chk("addrviol_rdvalid", readdatavalid, 0);
        step();
        read = 1'b0;
        @(negedge clk);
        chk("addrviol_idle", waitrequest, 0);
        chk_regs("addrviol");
        step();

        write       = 1'b1;
        address     = 8'h10;
        byteenable  = 2'b11;
        writedata   = 16'hAAAA;
        wait_cycles = 4'd3;
        step();
        writedata = 16'h5555;
        step();
        write = 1'b0;
        chk_regs("wdviol");
        step();
        xfer(1, 8'h10, 2'b00, 16'h0, 4'd1);

        write       = 1'b1;
        address     = 8'h20;
        byteenable  = 2'b11;
        writedata   = 16'hCAFE;
        wait_cycles = 4'd5;
        @(negedge clk);
        chk("mid_wait0", waitrequest, 1);
        step();
        @(negedge clk);
        chk("mid_wait1", waitrequest, 1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_waitreq", waitrequest, 0);
        step();
        model_reset();
        rst   = 1'b1;
        write = 1'b0;
        chk_regs("mid");
        step();
        xfer(1, 8'h20, 2'b00, 16'h0, 4'd0);

        for (int n = 0; n < 150; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
            xfer(($urandom_range(0, 1) == 1), a, 2'($urandom),
                 16'($urandom), 4'($urandom));
        end

        rst = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        read        = 1'b1;
        address     = 8'h05;
        wait_cycles = 4'd0;
        repeat (65535) step();
        @(negedge clk);
        chk("sat_rdvalid", readdatavalid, 1);
        chk("sat_ffff", rd_count, 16'hFFFF);
        step();
        step();
        read = 1'b0;
        @(negedge clk);
        chk("sat_nowrap", rd_count, 16'hFFFF);
        chk("sat_wrcnt", wr_count, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
